clk_recfg_ctrl: RTL and testbench

CLK_RECFG_CTRL -- requirements
Module: clk_recfg_ctrl

---
 rtl/clk_recfg_ctrl.sv | 163 ++++++++++++++++
 tb/tb_clk_recfg_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_recfg_ctrl.sv
// Clock reconfiguration sequencer: gates the clock, switches the bypass mux,
// optionally hands a new divider value over, then ungates and reports completion.
module clk_recfg_ctrl #(
  parameter int unsigned DIV_VALUE_WIDTH = 8,
  parameter int unsigned DEFAULT_DIV     = 1,
  parameter logic        DEFAULT_BYP     = 1'b0,
  parameter int unsigned GATE_CYCLES     = 4,
  parameter int unsigned SWITCH_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       sw_en_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_byp_i,
  input  logic [DIV_VALUE_WIDTH-1:0] cmd_div_i,
  output logic                       clk_en_o,
  output logic                       byp_en_o,
  output logic [DIV_VALUE_WIDTH-1:0] div_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int unsigned MAX_GS  = (GATE_CYCLES > SWITCH_CYCLES) ? GATE_CYCLES : SWITCH_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_GS > TIMEOUT_CYCLES) ? MAX_GS : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] GATE_LAST    = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SWITCH_LAST  = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DIV_VALUE_WIDTH-1:0] DEF_DIV = DIV_VALUE_WIDTH'(DEFAULT_DIV);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GATE,
    ST_SWITCH,
    ST_DIV,
    ST_DONE
  } state_e;

  state_e                     state_q,   state_d;
  logic                       gate_q,    gate_d;
  logic                       byp_q,     byp_d;
  logic [DIV_VALUE_WIDTH-1:0] div_q,     div_d;
  logic                       cmd_byp_q, cmd_byp_d;
  logic [DIV_VALUE_WIDTH-1:0] cmd_div_q, cmd_div_d;
  logic [CNT_W-1:0]           cnt_q,     cnt_d;
  logic                       err_q,     err_d;

  logic handshake;
  logic need_div;

  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign handshake   = cmd_valid_i && cmd_ready_o;

  // A zero divider or an unchanged one skips the divider handover entirely.
  assign need_div = (cmd_div_q != '0) && (cmd_div_q != div_q);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    gate_d    = gate_q;
    byp_d     = byp_q;
    div_d     = div_q;
    cmd_byp_d = cmd_byp_q;
    cmd_div_d = cmd_div_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          cmd_byp_d = cmd_byp_i;
          cmd_div_d = cmd_div_i;
          gate_d    = 1'b1;
          err_d     = 1'b0;
          cnt_d     = '0;
          state_d   = ST_GATE;
        end
      end

      ST_GATE: begin
        if (cnt_q == GATE_LAST) begin
          cnt_d   = '0;
          byp_d   = cmd_byp_q;
          state_d = ST_SWITCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SWITCH: begin
        if (cnt_q == SWITCH_LAST) begin
          cnt_d   = '0;
          state_d = need_div ? ST_DIV : ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DIV: begin
        // Ready is tested before the timeout so a last-cycle accept still commits.
        if (div_ready_i) begin
          div_d   = cmd_div_q;
          state_d = ST_DONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        gate_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (rst_i) begin
      state_q   <= ST_IDLE;
      gate_q    <= 1'b0;
      byp_q     <= DEFAULT_BYP;
      div_q     <= DEF_DIV;
      cmd_byp_q <= 1'b0;
      cmd_div_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gate_q    <= gate_d;
      byp_q     <= byp_d;
      div_q     <= div_d;
      cmd_byp_q <= cmd_byp_d;
      cmd_div_q <= cmd_div_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // div_q only ever holds the committed value, so a timeout reverts for free.
  assign div_o       = (state_q == ST_DIV) ? cmd_div_q : div_q;
  assign div_valid_o = (state_q == ST_DIV) && gate_q;
  assign clk_en_o    = sw_en_i && !gate_q;
  assign byp_en_o    = byp_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_clk_recfg_ctrl.sv
// Self-checking bench for clk_recfg_ctrl: expected sequence outcomes are queued
// at command acceptance and compared when done_o fires.
module tb_clk_recfg_ctrl;

  localparam int W = 8;
  localparam int G = 4;
  localparam int S = 4;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         sw_en_i;
  logic         cmd_valid_i;
  logic         cmd_ready_o;
  logic         cmd_byp_i;
  logic [W-1:0] cmd_div_i;
  logic         clk_en_o;
  logic         byp_en_o;
  logic [W-1:0] div_o;
  logic         div_valid_o;
  logic         div_ready_i;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  typedef struct {
    logic         byp;
    logic [W-1:0] div;
    logic         err;
    int           lat;
    int           dv;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  logic         m_byp;
  logic [W-1:0] m_div;

  always #5 clk = ~clk;

  clk_recfg_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .sw_en_i     (sw_en_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_byp_i   (cmd_byp_i),
    .cmd_div_i   (cmd_div_i),
    .clk_en_o    (clk_en_o),
    .byp_en_o    (byp_en_o),
    .div_o       (div_o),
    .div_valid_o (div_valid_o),
    .div_ready_i (div_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered at a falling edge; returns at the falling edge inside DONE.
  // ready_at = DIV cycle in which div_ready_i is raised (0 = never).
  task automatic run_cmd(input logic byp, input logic [W-1:0] div, input int ready_at,
                         input bit hold, input bit chained);
    exp_t         e;
    logic         old_byp;
    int           w, k, dv, bad;
    bit           seen;
    cmd_valid_i = 1'b1;
    cmd_byp_i   = byp;
    cmd_div_i   = div;
    w = 0;
    while (!cmd_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (chained) check("b2b_accept_wait", w, 1);
    check("cmd_ready", {31'd0, cmd_ready_o}, 1);

    e.byp = byp;
    e.err = 1'b0;
    e.div = m_div;
    e.dv  = 0;
    if (div != '0 && div != m_div) begin
      if (ready_at >= 1 && ready_at <= T) begin
        e.dv  = ready_at;
        e.div = div;
      end else begin
        e.dv  = T;
        e.err = 1'b1;
      end
    end
    e.lat = G + S + e.dv + 1;
    sb.push_back(e);
    old_byp = m_byp;
    m_byp   = e.byp;
    m_div   = e.div;

    @(negedge clk);
    if (!hold) cmd_valid_i = 1'b0;
    k = 1; dv = 0; bad = 0; seen = 0;
    while (k <= 200) begin
      if (clk_en_o !== 1'b0) bad++;
      if (k == G)     check("byp_before_switch", {31'd0, byp_en_o}, {31'd0, old_byp});
      if (k == G + 1) check("byp_on_switch", {31'd0, byp_en_o}, {31'd0, byp});
      if (div_valid_o) begin
        dv++;
        if (dv == 1) check("div_o_in_div", {24'd0, div_o}, {24'd0, div});
        div_ready_i = (dv == ready_at);
      end else begin
        div_ready_i = 1'b0;
      end
      if (done_o) begin
        seen = 1;
        break;
      end
      @(negedge clk);
      k++;
    end
    div_ready_i = 1'b0;
    check("done_seen", {31'd0, seen}, 1);
    e = sb.pop_front();
    if (seen) begin
      check("latency", k, e.lat);
      check("err_o", {31'd0, err_o}, {31'd0, e.err});
      check("byp_en_o", {31'd0, byp_en_o}, {31'd0, e.byp});
      check("div_o_final", {24'd0, div_o}, {24'd0, e.div});
      check("div_valid_cycles", dv, e.dv);
      check("busy_in_done", {31'd0, busy_o}, 1);
    end
    check("clk_en_gated", bad, 0);
  endtask

  task automatic after_idle();
    @(negedge clk);
    check("clk_en_after_done", {31'd0, clk_en_o}, {31'd0, sw_en_i});
    check("busy_idle", {31'd0, busy_o}, 0);
    check("done_idle", {31'd0, done_o}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    bit any_done;
    rst_i = 1'b1; sw_en_i = 1'b1; cmd_valid_i = 1'b0; cmd_byp_i = 1'b0;
    cmd_div_i = '0; div_ready_i = 1'b0;
    m_byp = 1'b0; m_div = 8'd1;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy_o}, 0);
    check("rst_done", {31'd0, done_o}, 0);
    check("rst_err", {31'd0, err_o}, 0);
    check("rst_div_valid", {31'd0, div_valid_o}, 0);
    check("rst_byp", {31'd0, byp_en_o}, 0);
    check("rst_div", {24'd0, div_o}, 1);
    check("rst_cmd_ready", {31'd0, cmd_ready_o}, 0);
    check("rst_clk_en_1", {31'd0, clk_en_o}, 1);
    sw_en_i = 1'b0; #1;
    check("rst_clk_en_0", {31'd0, clk_en_o}, 0);
    sw_en_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("idle_cmd_ready", {31'd0, cmd_ready_o}, 1);

    // Bypass only, no divider change.
    run_cmd(1'b1, 8'd0, 0, 0, 0);
    after_idle();
    // Divider never accepted: timeout, revert, error.
    run_cmd(1'b1, 8'd8, 0, 0, 0);
    after_idle();
    // Ready in the very last allowed DIV cycle.
    run_cmd(1'b0, 8'd8, T, 0, 0);
    after_idle();
    // Same divider as current: no DIV phase; same bypass still gates.
    run_cmd(1'b0, 8'd8, 1, 0, 0);
    after_idle();
    // Ready in the third DIV cycle.
    run_cmd(1'b0, 8'd5, 3, 0, 0);
    after_idle();
    for (int i = 0; i < 4; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom_range(0, 3)),
              int'($urandom_range(1, 5)), 0, 0);
      after_idle();
    end

    // Reset in the middle of the DIV phase aborts without a done pulse.
    cmd_valid_i = 1'b1; cmd_byp_i = 1'b1; cmd_div_i = 8'd9;
    w = 0;
    while (!cmd_ready_o && w < 50) begin @(negedge clk); w++; end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    w = 0;
    while (!div_valid_o && w < 50) begin @(negedge clk); w++; end
    check("abort_reached_div", {31'd0, div_valid_o}, 1);
    rst_i = 1'b1;
    @(negedge clk);
    check("abort_div_valid", {31'd0, div_valid_o}, 0);
    check("abort_byp", {31'd0, byp_en_o}, 0);
    check("abort_div", {24'd0, div_o}, 1);
    check("abort_busy", {31'd0, busy_o}, 0);
    check("abort_done", {31'd0, done_o}, 0);
    check("abort_clk_en", {31'd0, clk_en_o}, 1);
    rst_i = 1'b0;
    any_done = 0;
    repeat (4) begin
      @(negedge clk);
      any_done |= done_o;
    end
    check("abort_no_done", {31'd0, any_done}, 0);
    m_byp = 1'b0; m_div = 8'd1;

    // Back-to-back with cmd_valid held and the software enable off.
    sw_en_i = 1'b0;
    run_cmd(1'b1, 8'd2, 2, 1, 0);
    run_cmd(1'b0, 8'd0, 0, 0, 1);
    after_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
